// File: rtl/hs32_mem_arbiter_if.sv
// hs32 memory request bus: fetch port, execute port and single-port backend.
// Modport slave is the arbiter's view; master is the CPU/memory side.
interface hs32_mem_arbiter_if;
  logic [31:0] addr_f;
  logic        reqm_f;
  logic [31:0] dtr_f;
  logic        rdym_f;

  logic [31:0] addr_e;
  logic [31:0] dtw_e;
  logic        rw_e;
  logic        reqm_e;
  logic [31:0] dtr_e;
  logic        rdym_e;

  logic [31:0] mem_addr;
  logic [31:0] mem_dtw;
  logic        mem_we;
  logic        mem_en;
  logic [31:0] mem_dtr;

  modport slave (
    input  addr_f, reqm_f, addr_e, dtw_e, rw_e, reqm_e, mem_dtr,
    output dtr_f, rdym_f, dtr_e, rdym_e, mem_addr, mem_dtw, mem_we, mem_en
  );

  modport master (
    output addr_f, reqm_f, addr_e, dtw_e, rw_e, reqm_e, mem_dtr,
    input  dtr_f, rdym_f, dtr_e, rdym_e, mem_addr, mem_dtw, mem_we, mem_en
  );
endinterface

// File: rtl/hs32_mem_arbiter.sv
// Two-initiator (fetch / execute) arbiter driving a fixed-latency single-port
// memory; alternates grants under contention, one access per LATENCY+3 cycles.
module hs32_mem_arbiter #(
  parameter int          LATENCY  = 1,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  hs32_mem_arbiter_if.slave bus
);

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("hs32_mem_arbiter: LATENCY must be in 1..4");
  end
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("hs32_mem_arbiter: RESET_PC must be word aligned");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
  typedef enum logic {PORT_F, PORT_E} port_t;

  localparam logic [1:0] CNT_LOAD = 2'(LATENCY - 1);

  state_t      state_q, state_d;
  port_t       last_grant_q, last_grant_d;
  port_t       sel_q, sel_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        rw_q, rw_d;
  logic        rdym_f_q, rdym_f_d;
  logic        rdym_e_q, rdym_e_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] dtr_f_q, dtr_f_d;
  logic [31:0] dtr_e_q, dtr_e_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_dtw_q, mem_dtw_d;
  logic        pick_e;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_F;
      sel_q        <= PORT_F;
      cnt_q        <= 2'd0;
      rw_q         <= 1'b0;
      rdym_f_q     <= 1'b0;
      rdym_e_q     <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      dtr_f_q      <= 32'd0;
      dtr_e_q      <= 32'd0;
      mem_addr_q   <= 32'd0;
      mem_dtw_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      rw_q         <= rw_d;
      rdym_f_q     <= rdym_f_d;
      rdym_e_q     <= rdym_e_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      dtr_f_q      <= dtr_f_d;
      dtr_e_q      <= dtr_e_d;
      mem_addr_q   <= mem_addr_d;
      mem_dtw_q    <= mem_dtw_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    rw_d         = rw_q;
    dtr_f_d      = dtr_f_q;
    dtr_e_d      = dtr_e_q;
    mem_addr_d   = mem_addr_q;
    mem_dtw_d    = mem_dtw_q;
    rdym_f_d     = 1'b0;
    rdym_e_d     = 1'b0;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    pick_e       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.reqm_f || bus.reqm_e) begin
          // Under contention the port that did not win last time goes next.
          if (bus.reqm_f && bus.reqm_e) pick_e = (last_grant_q == PORT_F);
          else                          pick_e = bus.reqm_e;
          sel_d      = pick_e ? PORT_E : PORT_F;
          mem_addr_d = pick_e ? bus.addr_e : bus.addr_f;
          mem_dtw_d  = bus.dtw_e;
          rw_d       = pick_e & bus.rw_e;
          // Registered outputs: the strobe is visible during ACCESS.
          mem_en_d   = 1'b1;
          mem_we_d   = pick_e & bus.rw_e;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d        = CNT_LOAD;
        last_grant_d = sel_q;
        state_d      = WAIT;
      end
      WAIT: begin
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else begin
          if (!rw_q) begin
            if (sel_q == PORT_E) dtr_e_d = bus.mem_dtr;
            else                 dtr_f_d = bus.mem_dtr;
          end
          rdym_f_d = (sel_q == PORT_F);
          rdym_e_d = (sel_q == PORT_E);
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.dtr_f    = dtr_f_q;
  assign bus.rdym_f   = rdym_f_q;
  assign bus.dtr_e    = dtr_e_q;
  assign bus.rdym_e   = rdym_e_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_dtw  = mem_dtw_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_en   = mem_en_q;

endmodule

// File: tb/tb_hs32_mem_arbiter.sv
// Scoreboard bench for hs32_mem_arbiter: directed scenarios plus randomized
// concurrent fetch/execute traffic against a behavioural memory model.
module tb_hs32_mem_arbiter;
  localparam int LAT   = 2;
  localparam int BOUND = 100;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hs32_mem_arbiter_if bus();

  hs32_mem_arbiter #(.LATENCY(LAT), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] dtw;
    logic [31:0] dtr;
  } exp_t;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int gp = 0;
  int en_cyc = 0;
  exp_t f_q[$];
  exp_t e_q[$];
  int grant_log[$];
  int rdym_log[$];
  logic [31:0] fa_log[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] bmem[logic [31:0]];
  logic [31:0] last_e_rd = 32'd0;
  logic [32:0] pipe[LAT];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    $display("FAIL %s: no response within %0d cycles, expected one", name, BOUND);
  endtask

  task automatic push_f(input logic [31:0] a);
    exp_t x;
    x.addr = a; x.we = 1'b0; x.dtw = 32'd0; x.dtr = ref_rd(a);
    f_q.push_back(x);
  endtask

  task automatic push_e(input logic [31:0] a, input logic rw, input logic [31:0] d);
    exp_t x;
    x.addr = a; x.we = rw; x.dtw = d;
    if (rw) begin
      x.dtr = last_e_rd;
      ref_mem[a] = d;
    end else begin
      x.dtr = ref_rd(a);
      last_e_rd = x.dtr;
    end
    e_q.push_back(x);
  endtask

  task automatic fetch_req(input logic [31:0] a, input bit drop);
    bit got = 0;
    push_f(a);
    bus.addr_f = a;
    bus.reqm_f = 1'b1;
    for (int n = 0; n < BOUND; n++) begin
      @(negedge clk);
      if (drop && bus.mem_en && bus.mem_addr == a) bus.reqm_f = 1'b0;
      if (bus.rdym_f) begin got = 1; break; end
    end
    bus.reqm_f = 1'b0;
    if (!got) timeout_fail("fetch_rdym");
  endtask

  task automatic exec_req(input logic [31:0] a, input logic rw, input logic [31:0] d);
    bit got = 0;
    push_e(a, rw, d);
    bus.addr_e = a;
    bus.dtw_e  = d;
    bus.rw_e   = rw;
    bus.reqm_e = 1'b1;
    for (int n = 0; n < BOUND; n++) begin
      @(negedge clk);
      if (bus.rdym_e) begin got = 1; break; end
    end
    bus.reqm_e = 1'b0;
    if (!got) timeout_fail("exec_rdym");
  endtask

  task automatic check_reset_vals();
    chk("rst_rdym_f", 32'(bus.rdym_f), 32'd0);
    chk("rst_rdym_e", 32'(bus.rdym_e), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_dtr_f", bus.dtr_f, 32'd0);
    chk("rst_dtr_e", bus.dtr_e, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_dtw", bus.mem_dtw, 32'd0);
  endtask

  task automatic clear_model();
    f_q.delete();
    e_q.delete();
    last_e_rd = 32'd0;
  endtask

  // Backend SRAM: read data appears exactly LAT cycles after mem_en, noise otherwise.
  initial begin : backend
    logic [32:0] out;
    for (int k = 0; k < LAT; k++) pipe[k] = 33'd0;
    bus.mem_dtr = 32'd0;
    forever begin
      @(negedge clk);
      out = pipe[LAT-1];
      bus.mem_dtr = out[32] ? out[31:0] : $urandom;
      for (int k = LAT - 1; k > 0; k--) pipe[k] = pipe[k-1];
      pipe[0] = 33'd0;
      if (bus.mem_en === 1'b1) begin
        if (bus.mem_we) bmem[bus.mem_addr] = bus.mem_dtw;
        else pipe[0] = {1'b1, bmem.exists(bus.mem_addr) ? bmem[bus.mem_addr] : init_word(bus.mem_addr)};
      end
    end
  end

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (bus.rdym_f === 1'b1 || bus.rdym_e === 1'b1)
        chk("rdym_exclusive", 32'(bus.rdym_f & bus.rdym_e), 32'd0);
      if (bus.mem_en === 1'b1) begin
        if (f_q.size() > 0 && bus.mem_addr == f_q[0].addr) begin
          gp = 0;
          chk("fetch_mem_we", 32'(bus.mem_we), 32'd0);
          fa_log.push_back(bus.mem_addr);
        end else if (e_q.size() > 0 && bus.mem_addr == e_q[0].addr) begin
          gp = 1;
          chk("exec_mem_we", 32'(bus.mem_we), 32'(e_q[0].we));
          if (e_q[0].we) chk("exec_mem_dtw", bus.mem_dtw, e_q[0].dtw);
        end else begin
          gp = 2;
          checks++;
          $display("FAIL mem_en_addr: mem_addr %h matches no outstanding request", bus.mem_addr);
        end
        grant_log.push_back(gp);
        en_cyc = cyc;
      end
      if (bus.rdym_f === 1'b1) begin
        if (f_q.size() == 0) begin
          checks++;
          $display("FAIL rdym_f_unexpected: rdym_f=1 with no outstanding fetch, expected 0");
        end else begin
          x = f_q.pop_front();
          chk("dtr_f", bus.dtr_f, x.dtr);
          chk("rdym_f_latency", 32'(cyc - en_cyc), 32'(LAT + 1));
          chk("rdym_f_port", 32'(gp), 32'd0);
        end
        rdym_log.push_back(cyc);
      end
      if (bus.rdym_e === 1'b1) begin
        if (e_q.size() == 0) begin
          checks++;
          $display("FAIL rdym_e_unexpected: rdym_e=1 with no outstanding execute, expected 0");
        end else begin
          x = e_q.pop_front();
          chk("dtr_e", bus.dtr_e, x.dtr);
          chk("rdym_e_latency", 32'(cyc - en_cyc), 32'(LAT + 1));
          chk("rdym_e_port", 32'(gp), 32'd1);
        end
        rdym_log.push_back(cyc);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int nf;
    int ne;
    bit got;
    int exp_order[4];
    exp_order = '{1, 0, 1, 0};
    bus.addr_f = 32'd0; bus.reqm_f = 1'b0;
    bus.addr_e = 32'd0; bus.dtw_e = 32'd0; bus.rw_e = 1'b0; bus.reqm_e = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    reset = 1'b1;
    @(negedge clk);

    // Single fetch, then execute read / write / read-back through fetch.
    bmem[32'h100] = 32'hDEADBEEF;
    ref_mem[32'h100] = 32'hDEADBEEF;
    fetch_req(32'h100, 1'b0);
    exec_req(32'h1000, 1'b0, 32'd0);
    exec_req(32'h20, 1'b1, 32'h12345678);
    fetch_req(32'h20, 1'b0);

    // Streaming fetch.
    fa_log.delete();
    for (int i = 0; i < 4; i++) fetch_req(32'(i * 4), 1'b0);
    chk("stream_count", 32'(fa_log.size()), 32'd4);
    for (int i = 0; i < fa_log.size() && i < 4; i++) chk("stream_addr", fa_log[i], 32'(i * 4));

    // Dropped request still completes; arbiter keeps serving.
    fetch_req(32'h300, 1'b1);
    fetch_req(32'h304, 1'b0);

    // Reset while the access sits in WAIT.
    push_f(32'h400);
    bus.addr_f = 32'h400;
    bus.reqm_f = 1'b1;
    got = 0;
    for (int n = 0; n < BOUND; n++) begin
      @(negedge clk);
      if (bus.mem_en) begin got = 1; break; end
    end
    if (!got) timeout_fail("abort_mem_en");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals();
    clear_model();
    bus.reqm_f = 1'b0;
    reset = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    fetch_req(32'h40, 1'b0);

    // Sustained contention from a fresh reset.
    reset = 1'b0;
    repeat (2) @(negedge clk);
    clear_model();
    reset = 1'b1;
    @(negedge clk);
    grant_log.delete();
    rdym_log.delete();
    push_f(32'h200);
    push_e(32'h1100, 1'b0, 32'd0);
    bus.addr_f = 32'h200;
    bus.addr_e = 32'h1100; bus.rw_e = 1'b0; bus.dtw_e = 32'd0;
    bus.reqm_f = 1'b1;
    bus.reqm_e = 1'b1;
    nf = 0; ne = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus.rdym_f) begin
        nf++;
        if (nf < 2) begin push_f(32'h200 + 32'(4 * nf)); bus.addr_f = 32'h200 + 32'(4 * nf); end
        else bus.reqm_f = 1'b0;
      end
      if (bus.rdym_e) begin
        ne++;
        if (ne < 2) begin push_e(32'h1100 + 32'(4 * ne), 1'b0, 32'd0); bus.addr_e = 32'h1100 + 32'(4 * ne); end
        else bus.reqm_e = 1'b0;
      end
      if (nf >= 2 && ne >= 2) break;
    end
    bus.reqm_f = 1'b0;
    bus.reqm_e = 1'b0;
    if (nf < 2 || ne < 2) timeout_fail("contention_done");
    chk("contention_grants", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < grant_log.size() && i < 4; i++) chk("contention_order", 32'(grant_log[i]), 32'(exp_order[i]));
    for (int i = 1; i < rdym_log.size() && i < 4; i++) chk("contention_spacing", 32'(rdym_log[i] - rdym_log[i-1]), 32'(LAT + 3));

    // Randomized concurrent traffic.
    fork
      begin
        logic [31:0] fa;
        bit          fd;
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          fa = 32'($urandom_range(0, 1023)) << 2;
          fd = ($urandom_range(0, 5) == 0);
          fetch_req(fa, fd);
        end
      end
      begin
        logic [31:0] ea;
        logic        erw;
        logic [31:0] ed;
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          ea  = 32'h1000 + (32'($urandom_range(0, 63)) << 2);
          erw = 1'($urandom_range(0, 1));
          ed  = $urandom;
          exec_req(ea, erw, ed);
        end
      end
    join

    repeat (8) @(negedge clk);
    chk("fetch_queue_drained", 32'(f_q.size()), 32'd0);
    chk("exec_queue_drained", 32'(e_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
